// File: rtl/clk_tick_pkg.sv
// ----------------------------------------------------------------------------
// clk_tick_pkg : shared limits, channel mode/flag types and clog2 helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package clk_tick_pkg;

  localparam int N_CH_MIN = 1;
  localparam int N_CH_MAX = 16;
  localparam int W_MIN    = 2;
  localparam int W_MAX    = 32;

  typedef enum logic [1:0] {
    CH_HALT = 2'd0,
    CH_RUN  = 2'd1,
    CH_WRAP = 2'd2,
    CH_SYNC = 2'd3
  } ch_mode_e;

  typedef struct packed {
    logic pending;
    logic tick;
    logic clk_out;
  } ch_flags_t;

  // Select width for a channel index; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_tick_ch.sv
// ----------------------------------------------------------------------------
// clk_tick_ch : one divider channel with double-buffered divisor
// Rev 1.0 -- sync input present only with CLK_TICK_GEN_SYNC_EN
// ----------------------------------------------------------------------------
`default_nettype none

module clk_tick_ch
  import clk_tick_pkg::*;
#(
  parameter int             W       = 26,
  parameter logic [W-1:0]   DEF_DIV = {1'b1, {(W-1){1'b0}}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         wr,
  input  logic [W-1:0] wr_div,
`ifdef CLK_TICK_GEN_SYNC_EN
  input  logic         sync,
`endif
  output logic         tick,
  output logic         clk_out
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt;
  logic [W-1:0] div;
  logic [W-1:0] pend_div;
  ch_flags_t    flags;

  logic [W-1:0] nxt_div;
  logic         nxt_pend;
  ch_mode_e     mode;

  // A write landing on the same edge as a wrap/halt/sync is folded in here,
  // so it takes effect at that edge rather than one period later.
  always_comb begin
    nxt_div  = wr ? wr_div : pend_div;
    nxt_pend = wr | flags.pending;
    mode     = CH_RUN;
`ifdef CLK_TICK_GEN_SYNC_EN
    if (sync)
      mode = CH_SYNC;
    else
`endif
    if (!en || div == '0)
      mode = CH_HALT;
    else if (cnt == div - ONE)
      mode = CH_WRAP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      div      <= DEF_DIV;
      pend_div <= DEF_DIV;
      flags    <= '0;
    end else begin
      pend_div      <= nxt_div;
      flags.pending <= nxt_pend;
      flags.tick    <= 1'b0;
      case (mode)
        CH_SYNC: begin
          cnt           <= '0;
          flags.clk_out <= 1'b0;
          if (nxt_pend) begin
            div           <= nxt_div;
            flags.pending <= 1'b0;
          end
        end
        CH_HALT: begin
          if (nxt_pend) begin
            cnt           <= '0;
            div           <= nxt_div;
            flags.pending <= 1'b0;
          end
        end
        CH_WRAP: begin
          cnt           <= '0;
          flags.tick    <= 1'b1;
          flags.clk_out <= ~flags.clk_out;
          if (nxt_pend) begin
            div           <= nxt_div;
            flags.pending <= 1'b0;
          end
        end
        default: cnt <= cnt + ONE;
      endcase
    end
  end

  assign tick    = flags.tick;
  assign clk_out = flags.clk_out;

endmodule

`default_nettype wire

// File: rtl/clk_tick_gen.sv
// ----------------------------------------------------------------------------
// clk_tick_gen : N_CH programmable tick/clock dividers (option CLK_TICK_GEN_SYNC_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module clk_tick_gen
  import clk_tick_pkg::*;
#(
  parameter int           N_CH    = 4,
  parameter int           W       = 26,
  parameter logic [W-1:0] DEF_DIV = {1'b1, {(W-1){1'b0}}}
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_CH-1:0]               en,
  input  logic                          cfg_we,
  input  logic [clog2_min1(N_CH)-1:0]   cfg_ch,
  input  logic [W-1:0]                  cfg_div,
`ifdef CLK_TICK_GEN_SYNC_EN
  input  logic                          sync,
`endif
  output logic [N_CH-1:0]               tick,
  output logic [N_CH-1:0]               clk_out
);

  // Out-of-range cfg_ch values match no channel and are dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr;
    assign wr = cfg_we && (int'(cfg_ch) == i);

    clk_tick_ch #(
      .W       (W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[i]),
      .wr      (wr),
      .wr_div  (cfg_div),
`ifdef CLK_TICK_GEN_SYNC_EN
      .sync    (sync),
`endif
      .tick    (tick[i]),
      .clk_out (clk_out[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_tick_gen.sv
// ----------------------------------------------------------------------------
// tb_clk_tick_gen : directed self-checking bench for clk_tick_gen (N_CH=3, W=4)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_clk_tick_gen;

  localparam int BUDGET = 40;

  logic       clk;
  logic       rst_n;
  logic [2:0] en;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [3:0] cfg_div;
  logic [2:0] tick;
  logic [2:0] clk_out;
`ifdef CLK_TICK_GEN_SYNC_EN
  logic       sync;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  clk_tick_gen #(
    .N_CH    (3),
    .W       (4),
    .DEF_DIV (4'd8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
`ifdef CLK_TICK_GEN_SYNC_EN
    .sync    (sync),
`endif
    .tick    (tick),
    .clk_out (clk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Edges until tick[ch] is seen; BUDGET+1 means it never came.
  task automatic wait_tick(input int ch, input int budget, output int n);
    n = budget + 1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (tick[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic pulse_cfg(input logic [1:0] ch, input logic [3:0] div);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_div = div;
    @(negedge clk);
    cfg_we  = 1'b0;
  endtask

  // Write while halted: divisor loads immediately and count restarts at 0.
  task automatic load_halted(input int ch, input logic [3:0] div);
    en[ch]  = 1'b0;
    cfg_we  = 1'b1;
    cfg_ch  = 2'(ch);
    cfg_div = div;
    @(negedge clk);
    cfg_we  = 1'b0;
    en[ch]  = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    int   hits;
    logic c, nc;

    rst_n = 1'b0; en = 3'b000; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 4'd0;
`ifdef CLK_TICK_GEN_SYNC_EN
    sync  = 1'b0;
`endif
    cyc(2);
    check("rst_tick", {29'd0, tick}, 32'd0);
    check("rst_clk_out", {29'd0, clk_out}, 32'd0);

    // Default divisor 8: first tick 8 edges after release, clk_out period 16
    rst_n = 1'b1; en = 3'b111;
    wait_tick(0, BUDGET, n);
    check("def_first_tick", n, 8);
    check("def_all_tick", {29'd0, tick}, 32'd7);
    check("def_clk_out_hi", {29'd0, clk_out}, 32'd7);
    wait_tick(0, BUDGET, n);
    check("def_period", n, 8);
    check("def_clk_out_lo", {31'd0, clk_out[0]}, 32'd0);

    // Reprogram mid-period: D=5, write 3 at cnt=2
    load_halted(1, 4'd5);
    cyc(2);
    pulse_cfg(2'd1, 4'd3);
    wait_tick(1, BUDGET, n);
    check("reprog_remaining", n, 2);
    wait_tick(1, BUDGET, n);
    check("reprog_new_a", n, 3);
    wait_tick(1, BUDGET, n);
    check("reprog_new_b", n, 3);

    // D=1 ticks and toggles every cycle
    load_halted(0, 4'd1);
    c  = clk_out[0];
    nc = ~c;
    @(negedge clk);
    check("d1_tick_a", {31'd0, tick[0]}, 32'd1);
    check("d1_toggle_a", {31'd0, clk_out[0]}, {31'd0, nc});
    @(negedge clk);
    check("d1_tick_b", {31'd0, tick[0]}, 32'd1);
    check("d1_toggle_b", {31'd0, clk_out[0]}, {31'd0, c});

    // D=0 halts: the write's own wrap still ticks, then nothing
    pulse_cfg(2'd0, 4'd0);
    c    = clk_out[0];
    hits = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (tick[0]) hits++;
    end
    check("d0_no_tick", hits, 0);
    check("d0_frozen", {31'd0, clk_out[0]}, {31'd0, c});

    // Enable gating: D=6, drop en[2] at cnt=3 for 7 edges
    load_halted(2, 4'd6);
    cyc(3);
    en[2] = 1'b0;
    c     = clk_out[2];
    hits  = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (tick[2]) hits++;
    end
    check("gate_no_tick", hits, 0);
    check("gate_frozen", {31'd0, clk_out[2]}, {31'd0, c});
    en[2] = 1'b1;
    wait_tick(2, BUDGET, n);
    check("gate_resume", n, 3);
    wait_tick(2, BUDGET, n);
    check("gate_period", n, 6);

    // Write to cfg_ch=3 (no such channel) must change nothing
    pulse_cfg(2'd3, 4'd2);
    wait_tick(2, BUDGET, n);
    wait_tick(2, BUDGET, n);
    check("inv_ch2_period", n, 6);
    wait_tick(1, BUDGET, n);
    wait_tick(1, BUDGET, n);
    check("inv_ch1_period", n, 3);
    wait_tick(0, 10, n);
    check("inv_ch0_halted", n, 11);

    // Back-to-back writes 6 then 9 before the wrap: last one wins
    wait_tick(2, BUDGET, n);
    pulse_cfg(2'd2, 4'd6);
    pulse_cfg(2'd2, 4'd9);
    wait_tick(2, BUDGET, n);
    check("b2b_remaining", n, 4);
    wait_tick(2, BUDGET, n);
    check("b2b_new", n, 9);

`ifdef CLK_TICK_GEN_SYNC_EN
    // Sync with D=3,4 and a coincident write of 6 to channel 2
    load_halted(0, 4'd3);
    load_halted(1, 4'd4);
    cyc(2);
    sync    = 1'b1;
    cfg_we  = 1'b1;
    cfg_ch  = 2'd2;
    cfg_div = 4'd6;
    @(negedge clk);
    sync    = 1'b0;
    cfg_we  = 1'b0;
    check("sync_tick", {29'd0, tick}, 32'd0);
    check("sync_clk_out", {29'd0, clk_out}, 32'd0);
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (tick == 3'b111 && n == 0) n = k;
    end
    check("sync_align", n, 12);
`endif

    // Reset mid-period discards count and a pending write
    wait_tick(1, BUDGET, n);
    if (!clk_out[1]) wait_tick(1, BUDGET, n);
    pulse_cfg(2'd1, 4'd2);
    check("pre_rst_clk_out", {31'd0, clk_out[1]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_clk_out", {29'd0, clk_out}, 32'd0);
    check("async_rst_tick", {29'd0, tick}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(1, BUDGET, n);
    check("rst_mid_first", n, 8);
    check("rst_mid_all", {29'd0, tick}, 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clk_tick_gen.md
CLK_TICK_GEN -- requirements
Module: clk_tick_gen

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter W, default 26, divisor/counter width in bits (2..32).
REQ-003 SHALL have parameter DEF_DIV, default 2**(W-1), divisor loaded into every channel at reset.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  N_CH  per-channel run enable.
REQ-007 SHALL have port cfg_we  input  1  one-cycle divisor write strobe.
REQ-008 SHALL have port cfg_ch  input  clog2(N_CH) (min 1)  target channel of the write.
REQ-009 SHALL have port cfg_div  input  W  new divisor value.
REQ-010 SHALL have port tick  output  N_CH  one-cycle pulse per channel period.
REQ-011 SHALL have port clk_out  output  N_CH  registered square wave, toggles on every tick.

Function
REQ-012 SHALL hold, per channel, a W-bit counter cnt, active divisor D and pending divisor P with pending flag.
REQ-013 SHALL, with en[i]=1 and D>=1, count cnt 0..D-1 and wrap to 0, giving tick period D cycles and clk_out period 2D cycles.
REQ-014 SHALL assert tick[i] registered, in the cycle after cnt==D-1 is sampled, for exactly one cycle.
REQ-015 SHALL toggle clk_out[i] in the same cycle tick[i] is asserted.
REQ-016 SHALL, with D==1, assert tick[i] every cycle and toggle clk_out[i] every cycle.
REQ-017 SHALL, with en[i]=0, freeze cnt and clk_out[i] and hold tick[i] at 0; resume from the frozen count when en[i] returns to 1.
REQ-018 SHALL treat D==0 as channel halted, identical to en[i]=0.
REQ-019 SHALL, on cfg_we, store cfg_div into P of channel cfg_ch and set pending; writes with cfg_ch>=N_CH are ignored.
REQ-020 SHALL transfer P to D and clear pending at the wrap edge (cnt==D-1, running), so the new period starts cleanly from cnt=0.
REQ-021 SHALL transfer P to D on the next edge, with cnt cleared, when the channel is halted (en[i]=0 or D==0).
REQ-022 SHALL, on cfg_we coinciding with a wrap of the same channel, apply the new value at that wrap.
REQ-023 SHALL, on multiple writes before a wrap, keep only the last (last write wins).
REQ-024 SHALL never glitch clk_out; it is driven directly from a flop.

Reset
REQ-025 SHALL, on rst_n low, asynchronously set cnt=0, D=DEF_DIV, P=DEF_DIV, pending=0, tick=0, clk_out=0 for all channels.
REQ-026 SHALL release reset synchronously-safe: first count increment on the first clk edge with rst_n high and en[i]=1.
REQ-027 SHALL, on reset mid-period, discard the partial count and any pending write.

Configuration
REQ-028 SHALL, with macro CLK_TICK_GEN_SYNC_EN defined, add input sync (1 bit) that on assertion clears cnt and clk_out of all channels on the next edge, suppresses tick that cycle, and applies any pending divisor.
REQ-029 SHALL, without CLK_TICK_GEN_SYNC_EN, have no sync port and no sync logic.
REQ-030 SHALL give sync priority over wrap; a simultaneous cfg_we is still captured and applied by the sync.

Structure
REQ-031 SHALL place N_CH/W limits, clog2 helper and channel-state struct in package clk_tick_pkg.
REQ-032 SHALL instantiate one sub-module clk_tick_ch per channel via generate; top holds only write decode and sync fan-out.

Verification
REQ-033 SHALL cover reset default: W=4, DEF_DIV=8, en=1 -> first tick at cycle 8, clk_out period 16 cycles.
REQ-034 SHALL cover reprogram mid-period: D=5, at cnt=2 write 3 -> remaining period 5, next periods 3; no short tick.
REQ-035 SHALL cover D=1 and D=0: write 1 -> tick every cycle, clk_out toggles each cycle; write 0 -> tick stays 0, clk_out frozen.
REQ-036 SHALL cover enable gating: en[2] low for 7 cycles at cnt=3 -> counting resumes at 3, period stretched by exactly 7.
REQ-037 SHALL cover invalid channel and back-to-back writes: cfg_ch=N_CH ignored; writes 6 then 9 before wrap -> 9 applied.
REQ-038 SHALL cover (SYNC_EN) sync across channels with D=3,4,6 -> all clk_out=0, cnt=0 next cycle, common ticks realign at cycle 12.
